i2c_cmd_sequencer: RTL



---
 rtl/i2c_seq_pkg.sv | 25 ++
 rtl/i2c_cmd_sequencer_if.sv | 39 +++
 rtl/i2c_cmd_fifo.sv | 46 ++++
 rtl/i2c_cmd_sequencer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/i2c_seq_pkg.sv
// rtl/i2c_seq_pkg.sv - shared types and constants for the I2C command sequencer
package i2c_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_GAP    = 2'd3
    } seq_state_e;

    localparam logic [1:0] RSP_OK      = 2'b00;
    localparam logic [1:0] RSP_NACK    = 2'b01;
    localparam logic [1:0] RSP_TIMEOUT = 2'b10;

    localparam int CMD_W = 20;

    // FIFO entry layout {rd, dev, word, data}
    typedef struct packed {
        logic       rd;
        logic [2:0] dev;
        logic [7:0] word;
        logic [7:0] data;
    } cmd_t;

endpackage

// File: rtl/i2c_cmd_sequencer_if.sv
// rtl/i2c_cmd_sequencer_if.sv - command, engine and response signals of the sequencer
// slave : sequencer side (commands/engine results in, engine controls/responses out)
// master: host/engine side
interface i2c_cmd_sequencer_if;
    logic       i_cmd_valid;
    logic       o_cmd_ready;
    logic       i_cmd_rd;
    logic [2:0] i_cmd_dev;
    logic [7:0] i_cmd_word;
    logic [7:0] i_cmd_data;
    logic       o_wr_start_flag;
    logic       o_rd_start_flag;
    logic [2:0] o_device_addr;
    logic [7:0] o_word_addr;
    logic [7:0] o_wr_data;
    logic       i_i2c_done;
    logic       i_i2c_nack;
    logic [7:0] i_rd_data;
    logic       o_rsp_valid;
    logic [7:0] o_rsp_data;
    logic [1:0] o_rsp_err;
    logic       o_busy;

    modport slave (
        input  i_cmd_valid, i_cmd_rd, i_cmd_dev, i_cmd_word, i_cmd_data,
        input  i_i2c_done, i_i2c_nack, i_rd_data,
        output o_cmd_ready, o_wr_start_flag, o_rd_start_flag,
        output o_device_addr, o_word_addr, o_wr_data,
        output o_rsp_valid, o_rsp_data, o_rsp_err, o_busy
    );

    modport master (
        output i_cmd_valid, i_cmd_rd, i_cmd_dev, i_cmd_word, i_cmd_data,
        output i_i2c_done, i_i2c_nack, i_rd_data,
        input  o_cmd_ready, o_wr_start_flag, o_rd_start_flag,
        input  o_device_addr, o_word_addr, o_wr_data,
        input  o_rsp_valid, o_rsp_data, o_rsp_err, o_busy
    );
endinterface

// File: rtl/i2c_cmd_fifo.sv
// rtl/i2c_cmd_fifo.sv - synchronous FIFO (power-of-two DEPTH), full/empty from registered count
// Ports: clk, rst (async active-high), push_i/wdata_i, pop_i/rdata_o (head, show-ahead), full_o, empty_o
module i2c_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset: entries are only read once counted in
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/i2c_cmd_sequencer.sv
// rtl/i2c_cmd_sequencer.sv - queues I2C byte commands, launches them on the engine, returns ordered responses
// Ports: i_sys_clk, i_rst (async active-high), bus (slave modport: command in, engine control/result, response out, busy)
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int GAP_CYCLES     = 10
) (
    input logic                  i_sys_clk,
    input logic                  i_rst,
    i2c_cmd_sequencer_if.slave   bus
);
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int CNT_W = (TO_W > GAP_W) ? TO_W : GAP_W;
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    // GAP_CYCLES=0 still spends one cycle in GAP
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             alive_q;
    logic             wr_start_q, wr_start_d, rd_start_q, rd_start_d;
    logic             cmd_rd_q, cmd_rd_d;
    logic [2:0]       dev_q, dev_d;
    logic [7:0]       word_q, word_d, wdata_q, wdata_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic [1:0]       rsp_err_q, rsp_err_d;

    logic             push, pop, full, empty;
    cmd_t             push_entry, head;

    // Ready is held low until the first clock after reset release
    assign bus.o_cmd_ready = alive_q && !full;
    assign push            = bus.i_cmd_valid && bus.o_cmd_ready;
    assign push_entry      = '{rd: bus.i_cmd_rd, dev: bus.i_cmd_dev,
                               word: bus.i_cmd_word, data: bus.i_cmd_data};

    i2c_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (i_sys_clk),
        .rst     (i_rst),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_start_d  = 1'b0;
        rd_start_d  = 1'b0;
        cmd_rd_d    = cmd_rd_q;
        dev_d       = dev_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = 8'h00;
        rsp_err_d   = RSP_OK;
        pop         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    cmd_rd_d   = head.rd;
                    dev_d      = head.dev;
                    word_d     = head.word;
                    wdata_d    = head.data;
                    rd_start_d = head.rd;
                    wr_start_d = !head.rd;
                    state_d    = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // done takes priority over a timeout in the same cycle
                if (bus.i_i2c_done) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus.i_i2c_nack ? RSP_NACK : RSP_OK;
                    rsp_data_d  = (cmd_rd_q && !bus.i_i2c_nack) ? bus.i_rd_data : 8'h00;
                    cnt_d       = '0;
                    state_d     = ST_GAP;
                end else if (cnt_q == TO_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = RSP_TIMEOUT;
                    cnt_d       = '0;
                    state_d     = ST_GAP;
                end
            end
            ST_GAP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            alive_q     <= 1'b0;
            wr_start_q  <= 1'b0;
            rd_start_q  <= 1'b0;
            cmd_rd_q    <= 1'b0;
            dev_q       <= '0;
            word_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= RSP_OK;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alive_q     <= 1'b1;
            wr_start_q  <= wr_start_d;
            rd_start_q  <= rd_start_d;
            cmd_rd_q    <= cmd_rd_d;
            dev_q       <= dev_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.o_wr_start_flag = wr_start_q;
    assign bus.o_rd_start_flag = rd_start_q;
    assign bus.o_device_addr   = dev_q;
    assign bus.o_word_addr     = word_q;
    assign bus.o_wr_data       = wdata_q;
    assign bus.o_rsp_valid     = rsp_valid_q;
    assign bus.o_rsp_data      = rsp_data_q;
    assign bus.o_rsp_err       = rsp_err_q;
    assign bus.o_busy          = (state_q != ST_IDLE) || !empty;
endmodule
